// File: rtl/regfile_2w_sb.sv
// Register file with two read ports, two write ports (A = writeback, B = load return),
// write-through bypass, and a per-register busy scoreboard for outstanding load returns.
module regfile_2w_sb #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [AW-1:0]   Rreg_addr1,
  input  logic [AW-1:0]   Rreg_addr2,
  output logic [XLEN-1:0] Rdata1,
  output logic [XLEN-1:0] Rdata2,
  output logic            Busy1,
  output logic            Busy2,
  input  logic            RegWrite,
  input  logic [AW-1:0]   Wreg_addr,
  input  logic [XLEN-1:0] Wdata,
  input  logic            RegWrite_B,
  input  logic [AW-1:0]   Wreg_addr_B,
  input  logic [XLEN-1:0] Wdata_B,
  input  logic            Issue,
  input  logic [AW-1:0]   Issue_addr,
  input  logic            Flush,
  output logic            Wr_conflict
);

  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] r_busy;
  logic            r_conflict;

  logic            w_wr_a;
  logic            w_wr_b;
  logic            w_conflict;
  logic            w_store_b;
  logic [AW-1:0]   w_raddr [2];
  logic [XLEN-1:0] w_rdata [2];
  logic            w_busy  [2];

  // Writes to register 0 are discarded up front, so r0 can never be stored, bypassed or conflict.
  assign w_wr_a     = RegWrite   && (Wreg_addr   != '0);
  assign w_wr_b     = RegWrite_B && (Wreg_addr_B != '0);
  assign w_conflict = w_wr_a && w_wr_b && (Wreg_addr == Wreg_addr_B);
  assign w_store_b  = w_wr_b && !w_conflict;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the array is cleared by the async reset, so it maps to flops (or a RAM with clear), never a plain RAM macro.
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      if (w_store_b) r_mem[Wreg_addr_B] <= Wdata_B;
      if (w_wr_a)    r_mem[Wreg_addr]   <= Wdata;
    end
  end

  // Scoreboard: a same-cycle issue outranks both flush and load-return clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_busy <= '0;
    end else begin
      r_busy[0] <= 1'b0;
      for (int r = 1; r < NREG; r++) begin
        if (Issue && (Issue_addr == AW'(r)))
          r_busy[r] <= 1'b1;
        else if (Flush || (RegWrite_B && (Wreg_addr_B == AW'(r))))
          r_busy[r] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)          r_conflict <= 1'b0;
    else if (w_conflict) r_conflict <= 1'b1;
  end

  assign w_raddr[0] = Rreg_addr1;
  assign w_raddr[1] = Rreg_addr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
      w_rdata[p] = r_mem[w_raddr[p]];
      w_busy[p]  = 1'b0;
      if (w_raddr[p] == '0)
        w_rdata[p] = '0;
      else if (w_wr_a && (Wreg_addr == w_raddr[p]))
        w_rdata[p] = Wdata;
      else if (w_wr_b && (Wreg_addr_B == w_raddr[p]))
        w_rdata[p] = Wdata_B;
      if (w_raddr[p] != '0)
        w_busy[p] = r_busy[w_raddr[p]] && !(w_wr_b && (Wreg_addr_B == w_raddr[p]));
    end
  end

  assign Rdata1      = w_rdata[0];
  assign Rdata2      = w_rdata[1];
  assign Busy1       = w_busy[0];
  assign Busy2       = w_busy[1];
  assign Wr_conflict = r_conflict;

endmodule

// File: tb/tb_regfile_2w_sb.sv
// Self-checking bench for regfile_2w_sb: directed scenarios followed by randomized traffic,
// all compared against an array-based behavioural model of the register file and scoreboard.
module tb_regfile_2w_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [AW-1:0]   ra1, ra2, wa, wb, ia;
  logic [XLEN-1:0] rd1, rd2, wd, wdb;
  logic            b1, b2, we, web, iss, fl, conf;

  always #5 CLK = ~CLK;

  regfile_2w_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .Rreg_addr1(ra1), .Rreg_addr2(ra2), .Rdata1(rd1), .Rdata2(rd2),
    .Busy1(b1), .Busy2(b2),
    .RegWrite(we), .Wreg_addr(wa), .Wdata(wd),
    .RegWrite_B(web), .Wreg_addr_B(wb), .Wdata_B(wdb),
    .Issue(iss), .Issue_addr(ia), .Flush(fl),
    .Wr_conflict(conf)
  );

  logic [XLEN-1:0] m_mem  [NREG];
  bit              m_busy [NREG];
  bit              m_conf;
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_conf = 1'b0;
  endfunction

  // Value a reader should see this cycle, from stored state plus in-flight writes.
  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0)               return '0;
    if (we && wa == a)        return wd;
    if (web && wb == a)       return wdb;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return (a != 0) && m_busy[a] && !(web && wb == a);
  endfunction

  // Architectural update at a clock edge, written as the plain rules.
  function automatic void model_edge();
    if (we && web && wa != 0 && wa == wb) m_conf = 1'b1;
    if (web && wb != 0) m_mem[wb] = wdb;
    if (we && wa != 0)  m_mem[wa] = wd;
    if (fl) for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    if (web) m_busy[wb] = 1'b0;
    if (iss && ia != 0) m_busy[ia] = 1'b1;
    m_busy[0] = 1'b0;
  endfunction

  task automatic idle();
    we = 0; web = 0; iss = 0; fl = 0;
    wa = '0; wb = '0; ia = '0; wd = '0; wdb = '0;
  endtask

  task automatic compare();
    check("rdata1", rd1, exp_read(ra1));
    check("rdata2", rd2, exp_read(ra2));
    check("busy1", {31'd0, b1}, {31'd0, exp_busy(ra1)});
    check("busy2", {31'd0, b2}, {31'd0, exp_busy(ra2)});
    check("conflict", {31'd0, conf}, {31'd0, m_conf});
  endtask

  // Inputs are already driven; compare combinational outputs, clock once, update the model.
  task automatic step();
    #1 compare();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    RST_N = 1'b0;
    idle();
    ra1 = '0; ra2 = '0;
    model_reset();
    #12 RST_N = 1'b1;
    @(posedge CLK); #1;
    ra1 = 5'd5; ra2 = 5'd6;
    #1 check("reset_r5", rd1, 32'h0);
    check("reset_busy", {31'd0, b2}, 32'h0);

    // Reset mid-cycle clears storage and busy immediately.
    we = 1; wa = 5'd5; wd = 32'hDEAD_BEEF; iss = 1; ia = 5'd6;
    step();
    idle();
    #1 check("pre_reset_r5", rd1, 32'hDEAD_BEEF);
    check("pre_reset_busy6", {31'd0, b2}, 32'h1);
    #2 RST_N = 1'b0;
    #1 check("async_reset_r5", rd1, 32'h0);
    check("async_reset_busy6", {31'd0, b2}, 32'h0);
    check("async_reset_conf", {31'd0, conf}, 32'h0);
    model_reset();
    #2 RST_N = 1'b1;
    @(posedge CLK); #1;

    // Write-through bypass, then stored value.
    ra1 = 5'd7; we = 1; wa = 5'd7; wd = 32'h11;
    #1 check("bypass_r7", rd1, 32'h11);
    step();
    idle();
    #1 check("stored_r7", rd1, 32'h11);

    // Register 0: writes, issue and same-address A/B have no effect.
    ra1 = 5'd0; ra2 = 5'd0;
    we = 1; wa = 5'd0; wd = 32'hFFFF; web = 1; wb = 5'd0; wdb = 32'hFFFF; iss = 1; ia = 5'd0;
    #1 check("r0_bypass", rd1, 32'h0);
    step();
    idle();
    #1 check("r0_read", rd2, 32'h0);
    check("r0_busy", {31'd0, b1}, 32'h0);
    check("r0_no_conflict", {31'd0, conf}, 32'h0);

    // A/B conflict on r3: A wins in bypass and storage, flag is sticky.
    ra1 = 5'd3; ra2 = 5'd3;
    we = 1; wa = 5'd3; wd = 32'hAAAA; web = 1; wb = 5'd3; wdb = 32'hBBBB;
    #1 check("conflict_bypass", rd2, 32'hAAAA);
    step();
    idle();
    #1 check("conflict_stored", rd1, 32'hAAAA);
    check("conflict_flag", {31'd0, conf}, 32'h1);
    step();
    check("conflict_sticky", {31'd0, conf}, 32'h1);

    // Scoreboard set by issue, cleared and bypassed by load return.
    iss = 1; ia = 5'd9; ra1 = 5'd9;
    step();
    idle();
    #1 check("sb_busy9", {31'd0, b1}, 32'h1);
    web = 1; wb = 5'd9; wdb = 32'h55;
    #1 check("sb_return_busy", {31'd0, b1}, 32'h0);
    check("sb_return_data", rd1, 32'h55);
    step();
    idle();

    // Races: issue beats flush and beats load-return clear.
    iss = 1; ia = 5'd10;
    step();
    iss = 1; ia = 5'd4; fl = 1;
    step();
    idle();
    ra1 = 5'd4; ra2 = 5'd10;
    #1 check("race_flush_b4", {31'd0, b1}, 32'h1);
    check("race_flush_b10", {31'd0, b2}, 32'h0);
    iss = 1; ia = 5'd4; web = 1; wb = 5'd4; wdb = 32'h44;
    step();
    idle();
    #1 check("race_bclear_b4", {31'd0, b1}, 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      ra1 = rnd_addr(); ra2 = rnd_addr();
      we  = 1'($urandom_range(0, 1)); wa = rnd_addr(); wd  = $urandom;
      web = 1'($urandom_range(0, 2) == 0); wb = rnd_addr(); wdb = $urandom;
      iss = 1'($urandom_range(0, 1)); ia = rnd_addr();
      fl  = 1'($urandom_range(0, 15) == 0);
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
